dma_sequencer: RTL and testbench

Parametrised DMA channel sequencer for the console bus, successor to the fixed 8-channel controller. Holds the general-DMA and HDMA enable masks, runs the IDLE / general DMA / HDMA-init / HDMA-line phases, and issues a one-hot grant to `NCH` external per-channel engines. It adds selectable round-robin arbitration for general DMA, HDMA preemption of general DMA at unit boundaries with resume, and latched HDMA requests.

---
 rtl/dma_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_dma_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_sequencer.sv
// DMA channel sequencer: general DMA / HDMA phase control with one-hot grant to NCH channel engines.
// HDMA requests are latched every clk; everything else advances on cpu_en edges.
module dma_sequencer #(
   parameter int unsigned NCH = 8,
   parameter int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           cpu_en,
   input  logic           mdma_wr,
   input  logic           hdma_wr,
   input  logic [NCH-1:0] wdata,
   input  logic           rr_mode,
   input  logic           hdma_init,
   input  logic           hdma_start,
   input  logic [NCH-1:0] ch_finish,
   input  logic [NCH-1:0] ch_abort,
   input  logic           ch_unit_done,
   output logic           dma,
   output logic [1:0]     phase,
   output logic [NCH-1:0] grant,
   output logic [CHW-1:0] grant_idx,
   output logic [NCH-1:0] start_mask,
   output logic [NCH-1:0] mdma_en_q,
   output logic [NCH-1:0] hdma_en_q,
   output logic [NCH-1:0] hdma_act_q
);

   typedef enum logic [1:0] {IDLE = 2'd0, MDMA = 2'd1, HINIT = 2'd2, HLINE = 2'd3} state_t;

   state_t         state, state_n;
   logic [NCH-1:0] mdma_en, mdma_en_n;
   logic [NCH-1:0] hdma_en, hdma_en_n;
   logic [NCH-1:0] hdma_act, hdma_act_n;
   logic [NCH-1:0] line_mask, line_mask_n;
   logic [NCH-1:0] start_mask_n;
   logic [NCH-1:0] abort_bits;
   logic [CHW-1:0] rr_ptr, rr_ptr_n;
   logic           pend_init, pend_line;
   logic           start_cyc, start_cyc_n;
   logic           mdma_first, mdma_first_n;
   logic           clr_init, clr_line;
   logic           fin_hit;
   logic           enter_init, enter_line, enter_mdma;
   logic           set_init, set_line;

   assign set_init = hdma_init & (hdma_en != '0);
   assign set_line = hdma_start & (hdma_act != '0);

   // Grant: rotated lowest-set-bit search over the active source mask
   always_comb begin
      logic [NCH-1:0] src;
      int             base;
      int             j;
      logic           found;
      grant     = '0;
      grant_idx = '0;
      src       = '0;
      base      = 0;
      found     = 1'b0;
      j         = 0;
      case (state)
         MDMA: begin
            src = mdma_en;
            if (rr_mode) base = int'(rr_ptr);
         end
         HINIT, HLINE: if (!start_cyc) src = line_mask;
         default: ;
      endcase
      for (int i = 0; i < int'(NCH); i++) begin
         j = base + i;
         if (j >= int'(NCH)) j = j - int'(NCH);
         if (!found && src[j]) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = CHW'(j);
         end
      end
   end

   // Next-state and register-update logic
   always_comb begin
      state_n      = state;
      mdma_en_n    = mdma_en;
      hdma_en_n    = hdma_en;
      hdma_act_n   = hdma_act;
      line_mask_n  = line_mask;
      rr_ptr_n     = rr_ptr;
      start_mask_n = '0;
      start_cyc_n  = 1'b0;
      mdma_first_n = 1'b0;
      clr_init     = 1'b0;
      clr_line     = 1'b0;
      enter_init   = 1'b0;
      enter_line   = 1'b0;
      enter_mdma   = 1'b0;
      fin_hit      = |(ch_finish & grant);
      abort_bits   = start_cyc ? ch_abort : (ch_abort & grant);

      if (hdma_wr) begin
         hdma_en_n  = wdata;
         hdma_act_n = wdata;
      end
      if (mdma_wr) mdma_en_n = wdata;
      else if (state == MDMA) mdma_en_n = mdma_en & ~(ch_finish & grant);

      if (state == MDMA && fin_hit)
         rr_ptr_n = (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + CHW'(1);

      // An aborted channel never reports finish, so it leaves the current phase as well
      if (state == HINIT || state == HLINE) begin
         hdma_act_n  = hdma_act_n & ~abort_bits;
         line_mask_n = line_mask & ~((ch_finish & grant) | abort_bits);
         if (start_cyc && hdma_act_n == '0) line_mask_n = '0;
      end

      case (state)
         IDLE: begin
            if (pend_init)            enter_init = 1'b1;
            else if (pend_line)       enter_line = 1'b1;
            else if (mdma_en != '0)   enter_mdma = 1'b1;
         end
         MDMA: begin
            if ((pend_init || pend_line) && (ch_unit_done || mdma_first)) begin
               if (pend_init) enter_init = 1'b1;
               else           enter_line = 1'b1;
               if (!fin_hit && grant != '0) rr_ptr_n = grant_idx;
            end else if (mdma_en_n == '0) begin
               state_n = IDLE;
            end
         end
         HINIT: begin
            if (line_mask_n == '0) begin
               if (pend_line)               enter_line = 1'b1;
               else if (mdma_en_n != '0)    enter_mdma = 1'b1;
               else                         state_n    = IDLE;
            end
         end
         HLINE: begin
            if (line_mask_n == '0) begin
               if (pend_init)               enter_init = 1'b1;
               else if (mdma_en_n != '0)    enter_mdma = 1'b1;
               else                         state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (enter_init) begin
         state_n      = HINIT;
         hdma_act_n   = hdma_en_n;
         line_mask_n  = hdma_en_n;
         start_mask_n = hdma_en_n;
         start_cyc_n  = 1'b1;
         clr_init     = 1'b1;
      end
      if (enter_line) begin
         state_n      = HLINE;
         line_mask_n  = hdma_act_n;
         start_mask_n = hdma_act_n;
         start_cyc_n  = 1'b1;
         clr_line     = 1'b1;
      end
      if (enter_mdma) begin
         state_n      = MDMA;
         mdma_first_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         mdma_en    <= '0;
         hdma_en    <= '0;
         hdma_act   <= '0;
         line_mask  <= '0;
         rr_ptr     <= '0;
         pend_init  <= 1'b0;
         pend_line  <= 1'b0;
         start_cyc  <= 1'b0;
         mdma_first <= 1'b0;
         start_mask <= '0;
         dma        <= 1'b0;
      end else begin
         // A request landing on the same edge as its clear is kept
         pend_init <= set_init | (pend_init & ~(cpu_en & clr_init));
         pend_line <= set_line | (pend_line & ~(cpu_en & clr_line));
         if (cpu_en) begin
            state      <= state_n;
            mdma_en    <= mdma_en_n;
            hdma_en    <= hdma_en_n;
            hdma_act   <= hdma_act_n;
            line_mask  <= line_mask_n;
            rr_ptr     <= rr_ptr_n;
            start_cyc  <= start_cyc_n;
            mdma_first <= mdma_first_n;
            start_mask <= start_mask_n;
            dma        <= (state_n != IDLE);
         end
      end
   end

   assign phase      = state;
   assign mdma_en_q  = mdma_en;
   assign hdma_en_q  = hdma_en;
   assign hdma_act_q = hdma_act;

endmodule

// File: tb/tb_dma_sequencer.sv
// Directed bench for dma_sequencer: NCH=8 instance for arbitration/HDMA flows, NCH=3 for cpu_en gating.
module tb_dma_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cpu_en, mdma_wr, hdma_wr, rr_mode, hdma_init, hdma_start, ch_unit_done;
   logic [7:0] wdata, ch_finish, ch_abort;
   logic       dma;
   logic [1:0] phase;
   logic [7:0] grant, start_mask, mdma_en_q, hdma_en_q, hdma_act_q;
   logic [2:0] grant_idx;

   logic       g_cpu_en, g_hdma_wr, g_hdma_start, g_dma;
   logic [2:0] g_wdata, g_finish, g_grant, g_start_mask, g_mdma_en_q, g_hdma_en_q, g_hdma_act_q;
   logic [1:0] g_phase, g_grant_idx;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dma_sequencer #(.NCH(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en), .mdma_wr(mdma_wr), .hdma_wr(hdma_wr),
      .wdata(wdata), .rr_mode(rr_mode), .hdma_init(hdma_init), .hdma_start(hdma_start),
      .ch_finish(ch_finish), .ch_abort(ch_abort), .ch_unit_done(ch_unit_done),
      .dma(dma), .phase(phase), .grant(grant), .grant_idx(grant_idx), .start_mask(start_mask),
      .mdma_en_q(mdma_en_q), .hdma_en_q(hdma_en_q), .hdma_act_q(hdma_act_q)
   );

   dma_sequencer #(.NCH(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .cpu_en(g_cpu_en), .mdma_wr(1'b0), .hdma_wr(g_hdma_wr),
      .wdata(g_wdata), .rr_mode(1'b0), .hdma_init(1'b0), .hdma_start(g_hdma_start),
      .ch_finish(g_finish), .ch_abort(3'b000), .ch_unit_done(1'b0),
      .dma(g_dma), .phase(g_phase), .grant(g_grant), .grant_idx(g_grant_idx), .start_mask(g_start_mask),
      .mdma_en_q(g_mdma_en_q), .hdma_en_q(g_hdma_en_q), .hdma_act_q(g_hdma_act_q)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hold the current grant for cyc cycles, raising finish in the last one
   task automatic fin(input logic [7:0] m, input int cyc);
      repeat (cyc - 1) step();
      ch_finish = m;
      step();
      ch_finish = '0;
   endtask

   initial begin
      reset_n = 1'b0; cpu_en = 1'b1; mdma_wr = 1'b0; hdma_wr = 1'b0; rr_mode = 1'b0;
      hdma_init = 1'b0; hdma_start = 1'b0; ch_unit_done = 1'b0;
      wdata = '0; ch_finish = '0; ch_abort = '0;
      g_cpu_en = 1'b1; g_hdma_wr = 1'b0; g_hdma_start = 1'b0; g_wdata = '0; g_finish = '0;
      repeat (2) step();
      chk("rst_dma", 32'(dma), 32'h0);
      chk("rst_phase", 32'(phase), 32'h0);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_masks", 32'({mdma_en_q, hdma_en_q, hdma_act_q, start_mask}), 32'h0);
      reset_n = 1'b1;
      step();

      // Fixed priority: channels 2 then 5
      mdma_wr = 1'b1; wdata = 8'h24;
      step();
      mdma_wr = 1'b0;
      chk("fix_mask", 32'(mdma_en_q), 32'h24);
      chk("fix_idle", 32'(dma), 32'h0);
      step();
      chk("fix_phase", 32'(phase), 32'h1);
      chk("fix_g2", 32'(grant), 32'h04);
      chk("fix_i2", 32'(grant_idx), 32'd2);
      fin(8'h04, 3);
      chk("fix_g5", 32'(grant), 32'h20);
      chk("fix_i5", 32'(grant_idx), 32'd5);
      fin(8'h20, 3);
      chk("fix_done_dma", 32'(dma), 32'h0);
      chk("fix_done_mask", 32'(mdma_en_q), 32'h0);

      // Round-robin from a fresh pointer: 0, 2, 7, then wrap to re-enabled 2
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      rr_mode = 1'b1; mdma_wr = 1'b1; wdata = 8'h85;
      step();
      mdma_wr = 1'b0;
      step();
      chk("rr_g0", 32'(grant), 32'h01);
      fin(8'h01, 1);
      chk("rr_g2", 32'(grant), 32'h04);
      fin(8'h04, 1);
      chk("rr_g7", 32'(grant), 32'h80);
      mdma_wr = 1'b1; wdata = 8'h84;
      step();
      mdma_wr = 1'b0;
      chk("rr_g7_hold", 32'(grant), 32'h80);
      fin(8'h80, 1);
      chk("rr_wrap_g2", 32'(grant), 32'h04);
      chk("rr_wrap_i2", 32'(grant_idx), 32'd2);
      fin(8'h04, 1);
      chk("rr_end", 32'(dma), 32'h0);

      // HDMA line preempts general DMA on channel 1 at a unit boundary
      rr_mode = 1'b0; mdma_wr = 1'b1; hdma_wr = 1'b1; wdata = 8'h11;
      step();
      mdma_wr = 1'b0; hdma_wr = 1'b0;
      chk("pre_act", 32'(hdma_act_q), 32'h11);
      mdma_wr = 1'b1; wdata = 8'h02;
      step();
      mdma_wr = 1'b0;
      step();
      chk("pre_g1", 32'(grant), 32'h02);
      hdma_start = 1'b1;
      step();
      hdma_start = 1'b0;
      repeat (3) step();
      chk("pre_wait", 32'(phase), 32'h1);
      ch_unit_done = 1'b1;
      step();
      ch_unit_done = 1'b0;
      chk("pre_phase", 32'(phase), 32'h3);
      chk("pre_start", 32'(start_mask), 32'h11);
      chk("pre_start_g", 32'(grant), 32'h0);
      step();
      chk("pre_start_clr", 32'(start_mask), 32'h0);
      chk("pre_g0", 32'(grant), 32'h01);
      fin(8'h01, 1);
      chk("pre_g4", 32'(grant_idx), 32'd4);
      fin(8'h10, 1);
      chk("pre_resume_ph", 32'(phase), 32'h1);
      chk("pre_resume_g", 32'(grant), 32'h02);
      chk("pre_resume_dma", 32'(dma), 32'h1);
      fin(8'h02, 1);
      chk("pre_end", 32'(dma), 32'h0);

      // Abort of channel 1 during HINIT start cycle
      hdma_wr = 1'b1; wdata = 8'h06;
      step();
      hdma_wr = 1'b0; hdma_init = 1'b1;
      step();
      hdma_init = 1'b0;
      step();
      chk("ab_phase", 32'(phase), 32'h2);
      chk("ab_start", 32'(start_mask), 32'h06);
      ch_abort = 8'h02;
      step();
      ch_abort = '0;
      chk("ab_act", 32'(hdma_act_q), 32'h04);
      fin(8'h04, 1);
      chk("ab_idle", 32'(phase), 32'h0);
      hdma_start = 1'b1;
      step();
      hdma_start = 1'b0;
      step();
      chk("ab_line_start", 32'(start_mask), 32'h04);
      step();
      chk("ab_line_g", 32'(grant), 32'h04);
      fin(8'h04, 1);
      chk("ab_end", 32'(dma), 32'h0);

      // Request with empty mask is dropped
      hdma_wr = 1'b1; wdata = 8'h00;
      step();
      hdma_wr = 1'b0; hdma_init = 1'b1;
      step();
      hdma_init = 1'b0;
      repeat (2) step();
      chk("ign_phase", 32'(phase), 32'h0);
      chk("ign_dma", 32'(dma), 32'h0);

      // Simultaneous init+line: HINIT then HLINE back to back
      hdma_wr = 1'b1; wdata = 8'h03;
      step();
      hdma_wr = 1'b0; hdma_init = 1'b1; hdma_start = 1'b1;
      step();
      hdma_init = 1'b0; hdma_start = 1'b0;
      step();
      chk("cmb_hinit", 32'(phase), 32'h2);
      step();
      chk("cmb_g0", 32'(grant), 32'h01);
      fin(8'h01, 1);
      chk("cmb_g1", 32'(grant), 32'h02);
      fin(8'h02, 1);
      chk("cmb_hline", 32'(phase), 32'h3);
      chk("cmb_dma", 32'(dma), 32'h1);
      chk("cmb_start", 32'(start_mask), 32'h03);
      step();
      chk("cmb_line_g", 32'(grant), 32'h01);

      // Asynchronous reset in the middle of HLINE
      reset_n = 1'b0;
      #1;
      chk("arst_dma", 32'(dma), 32'h0);
      chk("arst_grant", 32'(grant), 32'h0);
      chk("arst_phase", 32'(phase), 32'h0);
      step();
      reset_n = 1'b1;
      step();
      chk("arst_stay", 32'({dma, phase}), 32'h0);
      chk("arst_en", 32'(hdma_en_q), 32'h0);

      // NCH=3: line request while cpu_en is low is served later
      g_hdma_wr = 1'b1; g_wdata = 3'b101;
      step();
      g_hdma_wr = 1'b0;
      chk("g_act", 32'(g_hdma_act_q), 32'h5);
      g_cpu_en = 1'b0;
      repeat (2) step();
      g_hdma_start = 1'b1;
      step();
      g_hdma_start = 1'b0;
      repeat (2) step();
      chk("g_hold", 32'(g_phase), 32'h0);
      g_cpu_en = 1'b1;
      step();
      chk("g_phase", 32'(g_phase), 32'h3);
      chk("g_start", 32'(g_start_mask), 32'h5);
      step();
      chk("g_g0", 32'(g_grant), 32'h1);
      g_finish = 3'b001;
      step();
      g_finish = '0;
      chk("g_i2", 32'(g_grant_idx), 32'd2);
      g_finish = 3'b100;
      step();
      g_finish = '0;
      chk("g_end", 32'(g_dma), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
